// File: rtl/aes64_ctrl_pkg.sv
// Shared definitions for the AES-128 block controller built around a 64-bit
// aes64 datapath.
//   - aes64_ctrl_state_e : controller state encoding
//   - AES64_CTRL_ROUNDS, AES64_CTRL_CYCLES_PER_ROUND : round structure
//   - xtime()            : GF(2^8) multiply-by-x used by the datapath
package aes64_ctrl_pkg;

  localparam int AES64_CTRL_ROUNDS           = 10;
  localparam int AES64_CTRL_CYCLES_PER_ROUND = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENC_HI = 3'd1,
    ENC_LO = 3'd2,
    KS1    = 3'd3,
    KS2_LO = 3'd4,
    KS2_HI = 3'd5,
    DONE   = 3'd6
  } aes64_ctrl_state_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes64_block_ctrl_aes64.sv
// Combinational 64-bit AES datapath (one operation per call).
// Ports:
//   valid            : operation enable; rd is zero when low
//   op_enc           : forward round half (SubBytes+ShiftRows[+MixColumns])
//   op_ks1           : key-schedule step 1 (RotWord/SubWord/Rcon), rnum = rs2[3:0]
//   op_ks2           : key-schedule step 2 (word XOR chain)
//   mix              : apply MixColumns for op_enc
//   hi               : op_enc returns the upper (1) or lower (0) 64-bit half
//   rs1, rs2 [63:0]  : operands; for op_enc the 128-bit state is {rs2, rs1}
//   rd [63:0]        : result
module aes64_block_ctrl_aes64
  import aes64_ctrl_pkg::*;
(
  input  logic        valid,
  input  logic        op_enc,
  input  logic        op_ks1,
  input  logic        op_ks2,
  input  logic        mix,
  input  logic        hi,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic [63:0] rd
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as the field inverse (x^254, zero maps to zero) followed by
  // the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnum);
    logic [7:0] r;
    case (rnum)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [127:0] st;
  logic [127:0] sr;
  logic [63:0]  sr_half;
  logic [63:0]  sb_in;
  logic [63:0]  sb_out;
  logic [63:0]  mc_out;
  logic [63:0]  enc_res;
  logic [63:0]  ks1_res;
  logic [63:0]  ks2_res;
  logic [31:0]  ks_word;
  logic [31:0]  ks_rot;
  logic [31:0]  ks2_w0;
  logic [3:0]   rnum;

  assign st = {rs2, rs1};

  genvar gi;

  // ShiftRows on the full state is pure wiring; byte r+4c takes row r, column (c+r)%4.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sr[8*gi +: 8] = st[8*SRC +: 8];
    end
  endgenerate

  assign sr_half = hi ? sr[127:64] : sr[63:0];

  // KS1 borrows the low four S-boxes for SubWord(RotWord(w3)).
  assign rnum    = rs2[3:0];
  assign ks_word = rs1[63:32];
  assign ks_rot  = (rnum == 4'hA) ? ks_word : {ks_word[7:0], ks_word[31:8]};
  assign sb_in   = op_ks1 ? {sr_half[63:32], ks_rot} : sr_half;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_sbox
      assign sb_out[8*gi +: 8] = sbox(sb_in[8*gi +: 8]);
    end
  endgenerate

  generate
    for (gi = 0; gi < 2; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sb_out[32*gi      +: 8];
      assign a1 = sb_out[32*gi + 8  +: 8];
      assign a2 = sb_out[32*gi + 16 +: 8];
      assign a3 = sb_out[32*gi + 24 +: 8];
      assign mc_out[32*gi      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_out[32*gi + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_out[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_out[32*gi + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  assign enc_res = mix ? mc_out : sb_out;
  assign ks1_res = {2{sb_out[31:0] ^ {24'd0, rcon(rnum)}}};
  assign ks2_w0  = rs1[63:32] ^ rs2[31:0];
  assign ks2_res = {ks2_w0 ^ rs2[63:32], ks2_w0};

  always_comb begin
    rd = '0;
    if (valid) begin
      if (op_ks1)      rd = ks1_res;
      else if (op_ks2) rd = ks2_res;
      else if (op_enc) rd = enc_res;
    end
  end

endmodule

// File: rtl/aes64_block_ctrl.sv
// AES-128 single-block encryption controller sequencing one aes64 datapath.
// Each round takes five cycles (ENC_HI, ENC_LO, KS1, KS2_LO, KS2_HI); the
// ciphertext is presented 51 cycles after the input handshake.
// Ports:
//   g_clk, g_resetn      : clock, asynchronous active-low reset
//   in_valid/in_ready    : job handshake (in_ready only in IDLE)
//   in_key, in_data      : 128-bit key and plaintext, byte i at [8i+7:8i]
//   out_valid/out_ready  : ciphertext handshake, held in DONE
//   out_data             : ciphertext, same byte order
//   busy                 : controller not in IDLE
//   abort                : cancel current job (only with AES64_CTRL_ABORT_EN)
// Build option: define AES64_CTRL_ABORT_EN to add the abort input.
module aes64_block_ctrl
  import aes64_ctrl_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES64_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(AES64_CTRL_ROUNDS - 1);

  aes64_ctrl_state_e state_reg, state_next;
  logic [127:0] data_reg, data_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] ns_reg, ns_next;
  logic [63:0]  tmp_reg, tmp_next;
  logic [3:0]   round_reg, round_next;
  logic [127:0] out_data_reg, out_data_next;

  logic        dp_valid;
  logic        dp_enc;
  logic        dp_ks1;
  logic        dp_ks2;
  logic        dp_mix;
  logic        dp_hi;
  logic [63:0] dp_rs1;
  logic [63:0] dp_rs2;
  logic [63:0] dp_rd;

  aes64_block_ctrl_aes64 u_aes64 (
    .valid  (dp_valid),
    .op_enc (dp_enc),
    .op_ks1 (dp_ks1),
    .op_ks2 (dp_ks2),
    .mix    (dp_mix),
    .hi     (dp_hi),
    .rs1    (dp_rs1),
    .rs2    (dp_rs2),
    .rd     (dp_rd)
  );

  // Operand steering. Both ENC halves read the state register, which is only
  // rewritten at the end of KS2_HI, so the round sees a consistent input.
  always_comb begin
    dp_valid = 1'b0;
    dp_enc   = 1'b0;
    dp_ks1   = 1'b0;
    dp_ks2   = 1'b0;
    dp_mix   = 1'b0;
    dp_hi    = 1'b0;
    dp_rs1   = '0;
    dp_rs2   = '0;
    case (state_reg)
      ENC_HI, ENC_LO: begin
        dp_valid = 1'b1;
        dp_enc   = 1'b1;
        dp_hi    = (state_reg == ENC_HI);
        dp_mix   = (round_reg != LAST_ROUND);
        dp_rs1   = data_reg[63:0];
        dp_rs2   = data_reg[127:64];
      end
      KS1: begin
        dp_valid = 1'b1;
        dp_ks1   = 1'b1;
        dp_rs1   = key_reg[127:64];
        dp_rs2   = {60'd0, round_reg};
      end
      KS2_LO: begin
        dp_valid = 1'b1;
        dp_ks2   = 1'b1;
        dp_rs1   = tmp_reg;
        dp_rs2   = key_reg[63:0];
      end
      KS2_HI: begin
        dp_valid = 1'b1;
        dp_ks2   = 1'b1;
        dp_rs1   = key_reg[63:0];
        dp_rs2   = key_reg[127:64];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    key_next      = key_reg;
    ns_next       = ns_reg;
    tmp_next      = tmp_reg;
    round_next    = round_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_data ^ in_key;
          key_next   = in_key;
          round_next = 4'd0;
          state_next = ENC_HI;
        end
      end
      ENC_HI: begin
        ns_next[127:64] = dp_rd;
        state_next      = ENC_LO;
      end
      ENC_LO: begin
        ns_next[63:0] = dp_rd;
        state_next    = KS1;
      end
      KS1: begin
        tmp_next   = dp_rd;
        state_next = KS2_LO;
      end
      KS2_LO: begin
        key_next[63:0] = dp_rd;
        state_next     = KS2_HI;
      end
      KS2_HI: begin
        // The round key is the freshly updated key, whose upper half is only
        // available combinationally this cycle.
        key_next[127:64] = dp_rd;
        data_next        = ns_reg ^ {dp_rd, key_reg[63:0]};
        if (round_reg == LAST_ROUND) begin
          out_data_next = ns_reg ^ {dp_rd, key_reg[63:0]};
          state_next    = DONE;
        end else begin
          round_next = round_reg + 4'd1;
          state_next = ENC_HI;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef AES64_CTRL_ABORT_EN
    // Abort wins over everything, including a result about to be published.
    if (abort && (state_reg != IDLE)) begin
      state_next    = IDLE;
      out_data_next = out_data_reg;
    end
`endif
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      key_reg      <= '0;
      ns_reg       <= '0;
      tmp_reg      <= '0;
      round_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      key_reg      <= key_next;
      ns_reg       <= ns_next;
      tmp_reg      <= tmp_next;
      round_reg    <= round_next;
      out_data_reg <= out_data_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_aes64_block_ctrl.sv
// Self-checking bench for aes64_block_ctrl: byte-level AES-128 reference
// model plus a cycle model of the handshake timing, checked every cycle, and
// directed scenarios (FIPS-197 vector, all-zero vector, output back-pressure,
// back-to-back jobs, mid-job reset, and abort when AES64_CTRL_ABORT_EN is set).
module tb_aes64_block_ctrl;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         abort_sig;
`ifdef AES64_CTRL_ABORT_EN
  logic         abort;
  assign abort_sig = abort;
`else
  assign abort_sig = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 g_clk = ~g_clk;

  aes64_block_ctrl dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES64_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // ---------------- reference AES-128 (byte oriented) ----------------
  logic [127:0] sbox_rows [16];
  initial begin
    sbox_rows = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    int j;
    row = sbox_rows[x[7:4]];
    j   = 15 - int'(x[3:0]);
    return row[8*j +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] nk [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[8*i +: 8];
      s[i] = pt[8*i +: 8] ^ k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[rw + 4*c] = sb(s[rw + 4*((c + rw) % 4)]);
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      nk[0] = k[0] ^ sb(k[13]) ^ rc;
      nk[1] = k[1] ^ sb(k[14]);
      nk[2] = k[2] ^ sb(k[15]);
      nk[3] = k[3] ^ sb(k[12]);
      for (int i = 4; i < 16; i++) nk[i] = k[i] ^ nk[i-4];
      k  = nk;
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // FIPS text order (first byte leftmost) to port order (byte 0 at [7:0]).
  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- cycle model ----------------
  logic         m_busy = 1'b0;
  int           m_cnt  = 0;     // cycles since the input handshake
  logic [127:0] m_res  = '0;

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (abort_sig && m_busy) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_res  <= aes_enc(in_key, in_data);
      end
    end else if (m_cnt < 51) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end
  end

  always @(negedge g_clk) begin
    chk("cyc_in_ready", 128'(in_ready), 128'(!m_busy));
    chk("cyc_busy", 128'(busy), 128'(m_busy));
    chk("cyc_out_valid", 128'(out_valid), 128'(m_busy && (m_cnt == 51)));
    if (m_busy && (m_cnt == 51)) chk("cyc_out_data", out_data, m_res);
  end

  // Handshake cycle stamps.
  int cyc = 0;
  int in_hs_cyc = 0;
  int out_hs_cyc = 0;
  always @(posedge g_clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) in_hs_cyc <= cyc;
    if (out_valid && out_ready) out_hs_cyc <= cyc;
  end

  // ---------------- directed stimulus ----------------
  logic [127:0] fk, fp, fc, zc;
  int lat;
  int first_out;

  // Presents a job and returns just after the handshake edge (+1).
  task automatic start_job(input logic [127:0] k, input logic [127:0] p, input logic keep);
    logic got;
    got      = 1'b0;
    in_key   = k;
    in_data  = p;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge g_clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout_fail("start_job");
    @(posedge g_clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Called in the first cycle after the handshake; returns at the negedge of
  // the first cycle with out_valid high, lat = cycles after the handshake.
  task automatic wait_valid(output int l);
    l = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge g_clk);
      if (out_valid) begin
        l = k;
        break;
      end
      @(posedge g_clk);
    end
    if (l == 0) timeout_fail("wait_valid");
  endtask

  task automatic do_job(input logic [127:0] k, input logic [127:0] p,
                        input logic [127:0] exp, input string name);
    int l;
    start_job(k, p, 1'b0);
    wait_valid(l);
    chk({name, "_latency"}, 128'(l), 128'(51));
    chk({name, "_data"}, out_data, exp);
    $display("[TB] job %s: key=%h pt=%h ct=%h latency=%0d", name, k, p, out_data, l);
    out_ready = 1'b1;
    @(posedge g_clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_key    = '0;
    in_data   = '0;
`ifdef AES64_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    fk = bswap(128'h000102030405060708090a0b0c0d0e0f);
    fp = bswap(128'h00112233445566778899aabbccddeeff);
    fc = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    zc = bswap(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    // Reset state.
    repeat (3) @(posedge g_clk);
    #1;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    g_resetn = 1'b1;

    // Pin the reference model to the published vectors.
    chk("model_fips", aes_enc(fk, fp), fc);
    chk("model_zero", aes_enc('0, '0), zc);

    // FIPS-197 vector with the result held for 20 cycles.
    start_job(fk, fp, 1'b0);
    wait_valid(lat);
    chk("fips_latency", 128'(lat), 128'(51));
    chk("fips_data", out_data, fc);
    $display("[TB] job fips_hold: ct=%h latency=%0d", out_data, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge g_clk);
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_out_data", out_data, fc);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge g_clk);
    #1;
    out_ready = 1'b0;

    // All-zero key and plaintext.
    do_job('0, '0, zc, "zero");

    // Back-to-back jobs with out_ready tied high.
    out_ready = 1'b1;
    start_job(fk, fp, 1'b1);
    in_key  = '0;
    in_data = '0;
    wait_valid(lat);
    chk("b2b1_latency", 128'(lat), 128'(51));
    chk("b2b1_data", out_data, fc);
    $display("[TB] job b2b1: ct=%h latency=%0d", out_data, lat);
    @(posedge g_clk);
    #1;
    first_out = out_hs_cyc;
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_gap", 128'(in_hs_cyc - first_out), 128'(1));
    wait_valid(lat);
    chk("b2b2_latency", 128'(lat), 128'(51));
    chk("b2b2_data", out_data, zc);
    $display("[TB] job b2b2: ct=%h latency=%0d", out_data, lat);
    @(posedge g_clk);
    #1;
    out_ready = 1'b0;

    // Reset pulsed in cycle 25 of a job.
    start_job(fk, fp, 1'b0);
    repeat (24) @(posedge g_clk);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    $display("[TB] job midrst: reset asserted in cycle 25");
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    do_job(fk, fp, fc, "after_reset");

`ifdef AES64_CTRL_ABORT_EN
    // Abort in cycle 10 of a job.
    start_job(fk, fp, 1'b0);
    repeat (9) @(posedge g_clk);
    #1;
    abort = 1'b1;
    @(posedge g_clk);
    #1;
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    $display("[TB] job abort: aborted in cycle 10");
    do_job(fk, fp, fc, "after_abort");
`endif

    repeat (3) @(posedge g_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
